// File: rtl/execute_stage_if.sv
// execute_stage_if: ID/EX inputs, flush/stall handshake and registered EX/MEM outputs of the EX stage
interface execute_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              IdEx_Valid;
    logic              IdEx_RegWrite;
    logic              IdEx_MemtoReg;
    logic              IdEx_MemRead;
    logic              IdEx_MemWrite;
    logic              IdEx_Branch;
    logic              IdEx_Jump;
    logic              IdEx_AluSrc;
    logic [3:0]        IdEx_AluOp;
    logic [DATA_W-1:0] IdEx_DataRs;
    logic [DATA_W-1:0] IdEx_DataRt;
    logic [DATA_W-1:0] IdEx_Imm;
    logic [DATA_W-1:0] IdEx_PcPlus4;
    logic [REG_AW-1:0] IdEx_AddrRdRt;
    logic              Flush;
    logic              Ex_Stall;
    logic              ExMem_Valid;
    logic              ExMem_RegWrite;
    logic              ExMem_MemtoReg;
    logic              ExMem_MemRead;
    logic              ExMem_MemWrite;
    logic              ExMem_Branch;
    logic              ExMem_Jump;
    logic              ExMem_Zero;
    logic [DATA_W-1:0] ExMem_AluOut;
    logic [DATA_W-1:0] ExMem_DataRt;
    logic [DATA_W-1:0] ExMem_BranchTarget;
    logic [REG_AW-1:0] ExMem_AddrRdRt;

    modport master (
        output IdEx_Valid, IdEx_RegWrite, IdEx_MemtoReg, IdEx_MemRead, IdEx_MemWrite,
               IdEx_Branch, IdEx_Jump, IdEx_AluSrc, IdEx_AluOp, IdEx_DataRs, IdEx_DataRt,
               IdEx_Imm, IdEx_PcPlus4, IdEx_AddrRdRt, Flush,
        input  Ex_Stall, ExMem_Valid, ExMem_RegWrite, ExMem_MemtoReg, ExMem_MemRead,
               ExMem_MemWrite, ExMem_Branch, ExMem_Jump, ExMem_Zero, ExMem_AluOut,
               ExMem_DataRt, ExMem_BranchTarget, ExMem_AddrRdRt
    );

    modport slave (
        input  IdEx_Valid, IdEx_RegWrite, IdEx_MemtoReg, IdEx_MemRead, IdEx_MemWrite,
               IdEx_Branch, IdEx_Jump, IdEx_AluSrc, IdEx_AluOp, IdEx_DataRs, IdEx_DataRt,
               IdEx_Imm, IdEx_PcPlus4, IdEx_AddrRdRt, Flush,
        output Ex_Stall, ExMem_Valid, ExMem_RegWrite, ExMem_MemtoReg, ExMem_MemRead,
               ExMem_MemWrite, ExMem_Branch, ExMem_Jump, ExMem_Zero, ExMem_AluOut,
               ExMem_DataRt, ExMem_BranchTarget, ExMem_AddrRdRt
    );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: pipeline EX stage (ALU, zero flag, branch target, EX/MEM bank); EX_MUL_EN builds the iterative multiplier
module execute_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic CLK,
    input logic RST,
    execute_stage_if.slave bus
);
    logic [DATA_W-1:0] a, b, diff, res, out_val;
    logic [REG_AW-1:0] rd;
    logic              fire;

    // Operand selection and single-cycle ALU
    always_comb begin
        a    = bus.IdEx_DataRs;
        b    = bus.IdEx_AluSrc ? bus.IdEx_Imm : bus.IdEx_DataRt;
        diff = a - b;
        rd   = bus.IdEx_AddrRdRt;
        case (bus.IdEx_AluOp)
            4'd0:    res = a + b;
            4'd1:    res = diff;
            4'd2:    res = a & b;
            4'd3:    res = a | b;
            4'd4:    res = a ^ b;
            4'd5:    res = ~(a | b);
            4'd6:    res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            4'd7:    res = a << b[4:0];
            4'd8:    res = a >> b[4:0];
            4'd9:    res = $signed(a) >>> b[4:0];
            default: res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    localparam int CW = $clog2(DATA_W);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] ma, mb, acc, prod;
    logic              start, last;

    // Multiplier step, stall and EX/MEM load qualification
    always_comb begin
        prod    = acc + (mb[cnt] ? ma << cnt : '0);
        start   = state == IDLE && bus.IdEx_Valid && bus.IdEx_AluOp == 4'd10 && !bus.Flush;
        last    = state == BUSY && cnt == CW'(DATA_W-1);
        fire    = !bus.Flush && bus.IdEx_Valid && (state == IDLE ? bus.IdEx_AluOp != 4'd10 : last);
        out_val = last ? prod : res;
    end

    assign bus.Ex_Stall = !RST && (start || (state == BUSY && !last && !bus.Flush));

    // Shift-add multiplier FSM; flush abandons the product
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            ma    <= '0;
            mb    <= '0;
            acc   <= '0;
        end else if (bus.Flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (start) begin
            state <= BUSY;
            cnt   <= '0;
            ma    <= a;
            mb    <= b;
            acc   <= '0;
        end else if (state == BUSY) begin
            acc   <= prod;
            cnt   <= last ? '0 : cnt + 1'b1;
            state <= last ? IDLE : BUSY;
        end
    end
`else
    // Without the multiplier every valid, unflushed instruction completes in one cycle
    always_comb begin
        fire    = !bus.Flush && bus.IdEx_Valid;
        out_val = res;
    end

    assign bus.Ex_Stall = 1'b0;
`endif

    // EX/MEM bank: loads the instruction when it fires, otherwise a bubble
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.ExMem_Valid        <= 1'b0;
            bus.ExMem_RegWrite     <= 1'b0;
            bus.ExMem_MemtoReg     <= 1'b0;
            bus.ExMem_MemRead      <= 1'b0;
            bus.ExMem_MemWrite     <= 1'b0;
            bus.ExMem_Branch       <= 1'b0;
            bus.ExMem_Jump         <= 1'b0;
            bus.ExMem_Zero         <= 1'b0;
            bus.ExMem_AluOut       <= '0;
            bus.ExMem_DataRt       <= '0;
            bus.ExMem_BranchTarget <= '0;
            bus.ExMem_AddrRdRt     <= '0;
        end else begin
            bus.ExMem_Valid        <= fire;
            bus.ExMem_RegWrite     <= fire && bus.IdEx_RegWrite;
            bus.ExMem_MemtoReg     <= fire && bus.IdEx_MemtoReg;
            bus.ExMem_MemRead      <= fire && bus.IdEx_MemRead;
            bus.ExMem_MemWrite     <= fire && bus.IdEx_MemWrite;
            bus.ExMem_Branch       <= fire && bus.IdEx_Branch;
            bus.ExMem_Jump         <= fire && bus.IdEx_Jump;
            bus.ExMem_Zero         <= fire && diff == '0;
            bus.ExMem_AluOut       <= fire ? out_val : '0;
            bus.ExMem_DataRt       <= fire ? bus.IdEx_DataRt : '0;
            bus.ExMem_BranchTarget <= fire ? bus.IdEx_PcPlus4 + (bus.IdEx_Imm << 2) : '0;
            bus.ExMem_AddrRdRt     <= fire ? rd : '0;
        end
    end
endmodule
